// File: rtl/demux_1to4_stream.sv
// Buffered 1-to-4 stream demultiplexer: each input beat is steered by its select tag
// into one of four 2-entry first-word-fall-through FIFOs that drain independently.
module demux_1to4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  logic [WIDTH-1:0] mem_r [4][2];
  logic [3:0]       wr_ptr_r;
  logic [3:0]       rd_ptr_r;
  logic [3:0][1:0]  cnt_r;
  logic [3:0]       push_s;
  logic [3:0]       pop_s;

  // Handshake decode; in_ready only looks at the addressed channel, never at out_ready
  always_comb begin
    in_ready  = (cnt_r[in_sel] != 2'd2);
    push_s    = 4'b0000;
    pop_s     = 4'b0000;
    out_valid = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      out_valid[n] = (cnt_r[n] != 2'd0);
      push_s[n]    = in_valid && in_ready && (in_sel == 2'(n));
      pop_s[n]     = (cnt_r[n] != 2'd0) && out_ready[n];
    end
  end

  // Per-channel storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 4'b0000;
      rd_ptr_r <= 4'b0000;
      cnt_r    <= '0;
      for (int n = 0; n < 4; n++) begin
        mem_r[n][0] <= '0;
        mem_r[n][1] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push_s[n]) begin
          mem_r[n][wr_ptr_r[n]] <= in_data;
          wr_ptr_r[n]           <= ~wr_ptr_r[n];
        end else begin
          wr_ptr_r[n] <= wr_ptr_r[n];
        end
        if (pop_s[n]) begin
          rd_ptr_r[n] <= ~rd_ptr_r[n];
        end else begin
          rd_ptr_r[n] <= rd_ptr_r[n];
        end
        // Simultaneous push and pop leaves occupancy unchanged
        case ({push_s[n], pop_s[n]})
          2'b10:   cnt_r[n] <= cnt_r[n] + 2'd1;
          2'b01:   cnt_r[n] <= cnt_r[n] - 2'd1;
          default: cnt_r[n] <= cnt_r[n];
        endcase
      end
    end
  end

  assign out_data0 = mem_r[0][rd_ptr_r[0]];
  assign out_data1 = mem_r[1][rd_ptr_r[1]];
  assign out_data2 = mem_r[2][rd_ptr_r[2]];
  assign out_data3 = mem_r[3][rd_ptr_r[3]];

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream: directed scenarios plus a random interleave,
// with a negedge monitor comparing the DUT against per-channel expected queues.
module tb_demux_1to4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] od [4];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_en   = 1'b0;
  logic [7:0] exp_q [4][$];

  demux_1to4_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: inputs and outputs are stable mid-cycle and describe what the next edge does
  always @(negedge clk) begin
    if (chk_en) begin
      bit acc;
      logic [1:0] sel;
      sel = in_sel;
      for (int n = 0; n < 4; n++)
        check($sformatf("out_valid[%0d]", n), 32'(out_valid[n]), 32'(exp_q[n].size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_q[sel].size() != 2));
      if (rst) begin
        for (int n = 0; n < 4; n++) exp_q[n].delete();
      end else begin
        acc = in_valid && (exp_q[sel].size() != 2);
        for (int n = 0; n < 4; n++) begin
          if (exp_q[n].size() != 0) begin
            check($sformatf("out_data%0d", n), 32'(od[n]), 32'(exp_q[n][0]));
            if (out_ready[n]) void'(exp_q[n].pop_front());
          end
        end
        if (acc) exp_q[sel].push_back(in_data);
      end
    end
  end

  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hFF; out_ready = 4'b1111;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    for (int n = 0; n < 4; n++) check($sformatf("rst out_data%0d", n), 32'(od[n]), 32'h0);

    // Single beat to channel 2
    step(1'b1, 2'd2, 8'hA5, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("single out_valid", 32'(out_valid), 32'h4);
    check("single out_data2", 32'(out_data2), 32'hA5);
    step(1'b0, 2'd0, 8'h00, 4'b0100);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("single drained", 32'(out_valid), 32'h0);

    // Fill channel 1, then back-pressure on sel 1 only
    step(1'b1, 2'd1, 8'h11, 4'b0000);
    step(1'b1, 2'd1, 8'h22, 4'b0000);
    step(1'b1, 2'd1, 8'h44, 4'b0000);
    @(negedge clk);
    check("full sel1 in_ready", 32'(in_ready), 32'h0);
    step(1'b1, 2'd0, 8'h33, 4'b0000);
    @(negedge clk);
    check("full sel0 in_ready", 32'(in_ready), 32'h1);
    step(1'b0, 2'd0, 8'h00, 4'b0010);
    @(negedge clk);
    check("drain1 first", 32'(out_data1), 32'h11);
    step(1'b0, 2'd0, 8'h00, 4'b0010);
    @(negedge clk);
    check("drain1 second", 32'(out_data1), 32'h22);
    step(1'b0, 2'd0, 8'h00, 4'b0001);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("fill drained", 32'(out_valid), 32'h0);

    // Back-to-back streaming into channel 3
    for (int i = 0; i < 8; i++) step(1'b1, 2'd3, 8'(i), 4'b1000);
    step(1'b0, 2'd0, 8'h00, 4'b1000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Random interleave
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 8'($urandom), 4'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 4'b1111);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("random drained", 32'(out_valid), 32'h0);

    // Reset mid-operation
    step(1'b1, 2'd0, 8'hA0, 4'b0000);
    step(1'b1, 2'd0, 8'hA1, 4'b0000);
    step(1'b1, 2'd3, 8'hB0, 4'b0000);
    step(1'b1, 2'd3, 8'hB1, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("pre-reset out_valid", 32'(out_valid), 32'h9);
    step(1'b1, 2'd0, 8'h99, 4'b1111);
    rst = 1'b1;
    step(1'b1, 2'd0, 8'hC3, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("mid-reset out_valid", 32'(out_valid), 32'h0);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("fresh out_valid", 32'(out_valid), 32'h1);
    check("fresh out_data0", 32'(out_data0), 32'hC3);
    step(1'b0, 2'd0, 8'h00, 4'b0001);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    check("fresh drained", 32'(out_valid), 32'h0);

    @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/demux_1to4_stream.md
# demux_1to4_stream

Buffered 1-to-4 stream demultiplexer: the receive-side counterpart of the team's 2:1/N:1 multiplexers. Each beat on the single input stream carries a 2-bit select tag and is routed into one of four per-channel 2-entry FIFOs. Each output channel drains independently under its own valid/ready handshake. Per-channel ordering is preserved, and a stalled channel never corrupts or reorders traffic on the others.

## Interface
- WIDTH, 8, data width of input and every output channel
- CLK  input  1  rising-edge clock; the only clock
- RST  input  1  reset, synchronous, active-high
- IN_DATA  input  WIDTH  input beat payload
- IN_SEL  input  2  destination channel of the current beat (0..3)
- IN_VALID  input  1  input beat present
- IN_READY  output  1  block can accept the beat currently addressed by IN_SEL
- OUT_DATA0..OUT_DATA3  output  WIDTH each  head-of-FIFO payload, channels 0..3
- OUT_VALID  output  4  bit n set = channel n holds at least one beat
- OUT_READY  input  4  bit n set = consumer n takes the head beat this cycle

## Operation
- Per channel n: 2-entry storage, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- IN_READY = (count[IN_SEL] != 2). This is combinational from current state and IN_SEL only, with no dependence on OUT_READY.
- Push: IN_VALID && IN_READY at the clock edge. IN_DATA is written to storage[IN_SEL][wr_ptr], wr_ptr toggles and count increments.
- Pop on channel n: OUT_VALID[n] && OUT_READY[n] at the clock edge. rd_ptr toggles and count decrements.
- Push and pop on the same channel in the same cycle: count unchanged and both pointers advance. This is legal only when count is 1, because a full channel deasserts IN_READY (no same-cycle pass-through on full).
- Push on channel a and pops on any other channels in the same cycle are independent.
- OUT_VALID[n] = (count[n] != 0). OUT_DATAn = storage[n][rd_ptr[n]], driven directly from registers (first-word fall-through).
- OUT_DATAn is checked only while OUT_VALID[n] = 1. Its value when empty is stale and not specified, except after reset.
- OUT_READY[n] asserted while OUT_VALID[n] = 0 has no effect.
- IN_SEL and IN_DATA are ignored when IN_VALID = 0.
- Ordering: beats for the same channel leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset (RST high at an edge): all counts and pointers go to 0, all storage goes to 0, and OUT_VALID = 4'b0000.
  - OUT_DATA0..3 = 0 and IN_READY = 1 in the cycle after reset.
  - Reset mid-operation discards all buffered beats.
  - A push or pop coincident with RST is ignored.
- Latency: a beat accepted at edge k shows OUT_VALID[n] = 1 with its data in the cycle after edge k. Minimum input-to-output latency is 1 cycle.
- Throughput: 1 beat/cycle sustained into any channel whose consumer holds OUT_READY high.
- Back-pressure: after 2 unpopped beats to channel n, IN_READY = 0 whenever IN_SEL = n. IN_READY stays 1 for other channels that are not full.
- Source rule: once IN_VALID is high with a given IN_SEL/IN_DATA, the source holds them until accepted. The block behaves correctly even if the source changes them, since acceptance is evaluated per cycle.
- Wrap: pointers are 1 bit and wrap 1 -> 0 naturally. Count never exceeds 2 or underflows below 0.

## Test plan
- Reset check: assert RST for 2 cycles with IN_VALID = 1 -> OUT_VALID = 0000, OUT_DATA0..3 = 0, IN_READY = 1, and nothing accepted.
- Single beat: IN_SEL = 2, IN_DATA = 8'hA5, one cycle, OUT_READY = 0000 -> next cycle OUT_VALID = 0100 and OUT_DATA2 = A5. Pop with OUT_READY = 0100 -> OUT_VALID = 0000.
- Fill/back-pressure: send 8'h11 and 8'h22 to channel 1 with OUT_READY = 0 -> IN_READY = 0 for SEL = 1 and 1 for SEL = 0.
  - Beat 8'h33 for SEL = 0 is still accepted.
  - Draining channel 1 yields 11 then 22.
- Streaming: 8 beats 8'h00..8'h07 to channel 3 back-to-back with OUT_READY[3] = 1 -> IN_READY held 1 throughout, 1-cycle latency, output order 00..07, and count never exceeds 1.
- Interleaved: random SEL and data with random OUT_READY over 1000 cycles -> a scoreboard confirms per-channel order, no loss or duplication, and IN_READY = 0 exactly when the addressed channel holds 2 beats.
- Reset mid-operation: channels 0 and 3 hold 2 beats each, then RST for 1 cycle -> all OUT_VALID = 0, and a fresh beat 8'hC3 to channel 0 emerges alone.
